bcd_operand_console: RTL and testbench

//  Button-driven decimal entry console for a compute core (e.g. rv32i_cpu GCD).
//  - Holds NUM_OPS operands of DIGITS_PER_OP BCD digits each, edited by cursor plus up/down.
//  - On start: converts the digits to binary and hands them to the core over a valid/ready handshake.
//  - Waits for the core's done, then converts the binary result back to BCD for the 7-seg scanner.
//  - Sits between the debounce instances and the core/seg_display in board tops.

---
 rtl/bcd_operand_console_pkg.sv | 25 ++
 rtl/bcd_operand_console_if.sv | 21 ++
 rtl/bcd_operand_console_bcd_bin_conv.sv | 76 +++++++
 rtl/bcd_operand_console.sv | 258 +++++++++++++++++++++++++
 tb/tb_bcd_operand_console.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_operand_console_pkg.sv
// Shared types and helpers for the BCD operand console.
package bcd_operand_console_pkg;

  typedef enum logic [2:0] {
    ST_EDIT = 3'd0,
    ST_CONV = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_B2D  = 3'd4,
    ST_SHOW = 3'd5
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Index width for a counter/selector over n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Decimal digits needed to hold any value of the given binary width.
  function automatic int bcd_digits(input int bits);
    return (bits * 301) / 1000 + 1;
  endfunction

endpackage

// File: rtl/bcd_operand_console_if.sv
// Operand/result handshake between the console (master) and the compute core (slave).
interface bcd_operand_console_if #(
  parameter int unsigned NUM_OPS = 2,
  parameter int unsigned OP_W    = 32
);
  logic                      op_valid;
  logic                      op_ready;
  logic [NUM_OPS*OP_W-1:0]   op_data;
  logic                      res_done;
  logic [OP_W-1:0]           res_data;

  modport master (
    output op_valid, op_data,
    input  op_ready, res_done, res_data
  );

  modport slave (
    input  op_valid, op_data,
    output op_ready, res_done, res_data
  );
endinterface

// File: rtl/bcd_operand_console_bcd_bin_conv.sv
// Sequential double-dabble: BIN_W-bit binary to BCD, one bit per cycle.
// start loads the value; done is high during the final shift cycle, and the
// bcd/ovf outputs hold their value until the next start.
module bcd_bin_conv
  import bcd_operand_console_pkg::*;
#(
  parameter int unsigned BIN_W = 32,
  parameter int unsigned OUT_D = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIN_W-1:0]     bin,
  output logic                 done,
  output logic [4*OUT_D-1:0]   bcd,
  output logic                 ovf
);

  localparam int FULL_D = (bcd_digits(BIN_W) > int'(OUT_D)) ? bcd_digits(BIN_W) : int'(OUT_D);
  localparam int CNT_W  = idx_w(BIN_W);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BIN_W - 1);

  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [4*FULL_D-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;

  // Load on start, otherwise add-3 then shift once per cycle while busy.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    adj    = bcd_q;
    for (int i = 0; i < FULL_D; i++) begin
      if (adj[4*i +: 4] > 4'd4) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    if (start) begin
      bin_d  = bin;
      bcd_d  = '0;
      cnt_d  = CNT_TOP;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {adj[4*FULL_D-2:0], bin_q[BIN_W-1]};
      bin_d = {bin_q[BIN_W-2:0], 1'b0};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) busy_d = 1'b0;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done = busy_q && (cnt_q == '0);
  assign bcd  = bcd_q[4*OUT_D-1:0];

  // Overflow: any nonzero digit above the displayable ones.
  if (FULL_D > int'(OUT_D)) begin : g_ovf
    assign ovf = |bcd_q[4*FULL_D-1:4*OUT_D];
  end else begin : g_no_ovf
    assign ovf = 1'b0;
  end

endmodule

// File: rtl/bcd_operand_console.sv
// Button-driven decimal operand entry, BCD->binary launch to a core, and
// binary->BCD display of the returned result.
// Optional build macro AUTO_REPEAT_EN: held up/down auto-repeats in EDIT.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  EDIT    | cursor / digit editing, start launches a conversion
//  CONV    | one digit per cycle, MSD first per operand, into op regs
//  REQ     | op_valid high, op_data frozen until op_ready
//  WAIT    | waiting for the core's res_done pulse
//  B2D     | double-dabble of the captured result (OP_W cycles)
//  SHOW    | result on display; udlr returns to EDIT, start relaunches
module bcd_operand_console
  import bcd_operand_console_pkg::*;
#(
  parameter int unsigned DIGITS_PER_OP = 2,
  parameter int unsigned NUM_OPS       = 2,
  parameter int unsigned OP_W          = 32
`ifdef AUTO_REPEAT_EN
  , parameter int unsigned REPEAT_DLY  = 50_000_000,
  parameter int unsigned REPEAT_PER    = 10_000_000
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   btn_up,
  input  logic                                   btn_down,
  input  logic                                   btn_left,
  input  logic                                   btn_right,
  input  logic                                   btn_start,
  bcd_operand_console_if.master                  core_if,
  output logic [4*NUM_OPS*DIGITS_PER_OP-1:0]     disp_bcd,
  output logic [idx_w(NUM_OPS*DIGITS_PER_OP)-1:0] cursor,
  output logic                                   show_res,
  output logic                                   busy,
  output logic                                   ovf
);

  localparam int N     = NUM_OPS * DIGITS_PER_OP;
  localparam int CUR_W = idx_w(N);
  localparam int DIG_W = idx_w(DIGITS_PER_OP);
  localparam int OPI_W = idx_w(NUM_OPS);
  localparam logic [CUR_W-1:0] TOP_IDX = CUR_W'(N - 1);
  localparam logic [DIG_W-1:0] DIG_TOP = DIG_W'(DIGITS_PER_OP - 1);
  localparam logic [OPI_W-1:0] OP_TOP  = OPI_W'(NUM_OPS - 1);

  state_e            state_q, state_d;
  logic [3:0]        dig_q [N];
  logic [3:0]        dig_d [N];
  logic [CUR_W-1:0]  cursor_q, cursor_d;
  logic [CUR_W-1:0]  conv_idx_q, conv_idx_d;
  logic [DIG_W-1:0]  conv_dig_q, conv_dig_d;
  logic [OPI_W-1:0]  conv_op_q, conv_op_d;
  logic [OP_W-1:0]   acc_q, acc_d;
  logic [OP_W-1:0]   op_q [NUM_OPS];
  logic [OP_W-1:0]   op_d [NUM_OPS];
  logic [4:0]        btn_prev_q, btn_prev_d;

  logic [4:0]        btn_vec, btn_rise;
  logic              rise_start, rise_up, rise_down, rise_left, rise_right;
  logic              step_up, step_dn, rpt_step_up, rpt_step_dn;
  logic              launch;
  logic [3:0]        conv_digit;
  logic [OP_W-1:0]   acc_next;
  logic              b2d_start, b2d_done, b2d_ovf;
  logic [4*N-1:0]    b2d_bcd;
  logic [NUM_OPS*OP_W-1:0] op_data_w;

  assign btn_vec    = {btn_start, btn_up, btn_down, btn_left, btn_right};
  assign btn_prev_d = btn_vec;
  assign btn_rise   = btn_vec & ~btn_prev_q;
  assign rise_start = btn_rise[4];
  assign rise_up    = btn_rise[3];
  assign rise_down  = btn_rise[2];
  assign rise_left  = btn_rise[1];
  assign rise_right = btn_rise[0];
  assign step_up    = rise_up | rpt_step_up;
  assign step_dn    = rise_down | rpt_step_dn;

`ifdef AUTO_REPEAT_EN
  logic [31:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_act_q, rpt_act_d;
  logic        rpt_dir_q, rpt_dir_d;

  // Repeat timer: armed by an up/down press in EDIT, down-counts while held.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_act_d   = rpt_act_q;
    rpt_dir_d   = rpt_dir_q;
    rpt_step_up = 1'b0;
    rpt_step_dn = 1'b0;
    if (state_q != ST_EDIT || rise_start) begin
      rpt_act_d = 1'b0;
      rpt_cnt_d = '0;
    end else if (rise_up || rise_down) begin
      rpt_act_d = 1'b1;
      rpt_dir_d = rise_up;
      rpt_cnt_d = 32'(REPEAT_DLY - 1);
    end else if (rpt_act_q) begin
      if (rpt_dir_q ? !btn_up : !btn_down) begin
        rpt_act_d = 1'b0;
        rpt_cnt_d = '0;
      end else if (rpt_cnt_q == '0) begin
        rpt_step_up = rpt_dir_q;
        rpt_step_dn = !rpt_dir_q;
        rpt_cnt_d   = 32'(REPEAT_PER - 1);
      end else begin
        rpt_cnt_d = rpt_cnt_q - 32'd1;
      end
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q <= '0;
      rpt_act_q <= 1'b0;
      rpt_dir_q <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_act_q <= rpt_act_d;
      rpt_dir_q <= rpt_dir_d;
    end
  end
`else
  assign rpt_step_up = 1'b0;
  assign rpt_step_dn = 1'b0;
`endif

  // Next-state logic: editing, digit conversion, handshake and result flow.
  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    cursor_d   = cursor_q;
    conv_idx_d = conv_idx_q;
    conv_dig_d = conv_dig_q;
    conv_op_d  = conv_op_q;
    acc_d      = acc_q;
    op_d       = op_q;
    launch     = 1'b0;
    b2d_start  = 1'b0;
    conv_digit = dig_q[conv_idx_q];
    acc_next   = (conv_dig_q == DIG_TOP) ? OP_W'(conv_digit)
                 : (acc_q << 3) + (acc_q << 1) + OP_W'(conv_digit);

    case (state_q)
      ST_EDIT: begin
        if (rise_start) begin
          launch = 1'b1;
        end else if (step_up) begin
          dig_d[cursor_q] = (dig_q[cursor_q] == BCD_MAX) ? 4'd0 : dig_q[cursor_q] + 4'd1;
        end else if (step_dn) begin
          dig_d[cursor_q] = (dig_q[cursor_q] == 4'd0) ? BCD_MAX : dig_q[cursor_q] - 4'd1;
        end else if (rise_left) begin
          cursor_d = (cursor_q == TOP_IDX) ? '0 : cursor_q + 1'b1;
        end else if (rise_right) begin
          cursor_d = (cursor_q == '0) ? TOP_IDX : cursor_q - 1'b1;
        end
      end
      ST_CONV: begin
        acc_d      = acc_next;
        conv_idx_d = conv_idx_q - 1'b1;
        if (conv_dig_q == '0) begin
          op_d[conv_op_q] = acc_next;
          conv_dig_d      = DIG_TOP;
          conv_op_d       = conv_op_q - 1'b1;
        end else begin
          conv_dig_d = conv_dig_q - 1'b1;
        end
        if (conv_idx_q == '0) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (core_if.op_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_if.res_done) begin
          b2d_start = 1'b1;
          state_d   = ST_B2D;
        end
      end
      ST_B2D: begin
        if (b2d_done) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (rise_start) launch = 1'b1;
        else if (rise_up || rise_down || rise_left || rise_right) state_d = ST_EDIT;
      end
      default: state_d = ST_EDIT;
    endcase

    // Conversion walks the flat digit index from the top down, which is MSD
    // first within each operand, highest operand first.
    if (launch) begin
      state_d    = ST_CONV;
      conv_idx_d = TOP_IDX;
      conv_dig_d = DIG_TOP;
      conv_op_d  = OP_TOP;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EDIT;
      cursor_q   <= '0;
      conv_idx_q <= '0;
      conv_dig_q <= '0;
      conv_op_q  <= '0;
      acc_q      <= '0;
      btn_prev_q <= '0;
      for (int i = 0; i < N; i++) dig_q[i] <= '0;
      for (int k = 0; k < NUM_OPS; k++) op_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      conv_idx_q <= conv_idx_d;
      conv_dig_q <= conv_dig_d;
      conv_op_q  <= conv_op_d;
      acc_q      <= acc_d;
      btn_prev_q <= btn_prev_d;
      dig_q      <= dig_d;
      op_q       <= op_d;
    end
  end

  bcd_bin_conv #(
    .BIN_W (OP_W),
    .OUT_D (N)
  ) u_b2d (
    .clk   (clk),
    .rst_n (rst_n),
    .start (b2d_start),
    .bin   (core_if.res_data),
    .done  (b2d_done),
    .bcd   (b2d_bcd),
    .ovf   (b2d_ovf)
  );

  // Pack operand registers (op0 in the LSBs) and choose the display source.
  always_comb begin
    op_data_w = '0;
    disp_bcd  = '0;
    for (int k = 0; k < NUM_OPS; k++) op_data_w[k*OP_W +: OP_W] = op_q[k];
    for (int i = 0; i < N; i++) begin
      if (state_q == ST_SHOW) disp_bcd[4*i +: 4] = b2d_ovf ? BCD_MAX : b2d_bcd[4*i +: 4];
      else                    disp_bcd[4*i +: 4] = dig_q[i];
    end
  end

  assign core_if.op_valid = (state_q == ST_REQ);
  assign core_if.op_data  = op_data_w;
  assign cursor           = cursor_q;
  assign show_res         = (state_q == ST_SHOW);
  assign busy             = (state_q == ST_CONV) || (state_q == ST_REQ) ||
                            (state_q == ST_WAIT) || (state_q == ST_B2D);
  assign ovf              = show_res && b2d_ovf;

endmodule

// File: tb/tb_bcd_operand_console.sv
// Directed + randomized bench for bcd_operand_console (default build).
module tb_bcd_operand_console;
  localparam int DPO  = 2;
  localparam int NOPS = 2;
  localparam int OPW  = 32;
  localparam int N    = DPO * NOPS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0;
  logic [4*N-1:0] disp_bcd;
  logic [1:0]     cursor;
  logic           show_res, busy, ovf;

  bcd_operand_console_if #(.NUM_OPS(NOPS), .OP_W(OPW)) core_if ();

  bcd_operand_console #(
    .DIGITS_PER_OP(DPO), .NUM_OPS(NOPS), .OP_W(OPW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_start(btn_start),
    .core_if(core_if),
    .disp_bcd(disp_bcd), .cursor(cursor),
    .show_res(show_res), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain decimal digits, cursor and display mode.
  int m_dig [N];
  int m_cur;
  bit m_show;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_dig[i] = 0;
    m_cur = 0;
    m_show = 0;
  endfunction

  function automatic logic [63:0] model_ops();
    longint unsigned v [NOPS];
    for (int k = 0; k < NOPS; k++) begin
      v[k] = 0;
      for (int j = DPO - 1; j >= 0; j--) v[k] = v[k] * 10 + longint'(m_dig[k*DPO + j]);
    end
    return {v[1][31:0], v[0][31:0]};
  endfunction

  function automatic logic [15:0] model_disp();
    logic [15:0] r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(m_dig[i]);
    return r;
  endfunction

  function automatic logic [15:0] model_res(input longint unsigned v);
    logic [15:0] r = '0;
    longint unsigned p = 1;
    if (v >= 10000) return 16'h9999;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_up = v;
      1: btn_down = v;
      2: btn_left = v;
      3: btn_right = v;
      default: btn_start = v;
    endcase
  endtask

  // Press/release one of up(0) down(1) left(2) right(3); called at a negedge.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    @(negedge clk);
    set_btn(b, 1'b0);
    @(negedge clk);
    if (m_show) m_show = 0;
    else case (b)
      0: m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
      1: m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
      2: m_cur = (m_cur + 1) % N;
      default: m_cur = (m_cur + N - 1) % N;
    endcase
  endtask

  task automatic set_digits(input int tgt [N]);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < N && m_cur != i; g++) press(2);
      for (int g = 0; g < 10 && m_dig[i] != tgt[i]; g++)
        press(((tgt[i] - m_dig[i] + 10) % 10 <= 5) ? 0 : 1);
    end
    check("set_disp", disp_bcd, model_disp());
  endtask

  // Start, check CONV timing and handshake, feed a result, check SHOW.
  task automatic compute(input int ready_delay, input longint unsigned res);
    int n;
    bit ok;
    logic [63:0] data0;
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    n = 0;
    ok = 1;
    while (core_if.op_valid !== 1'b1 && n < 50) begin
      if (busy !== 1'b1) ok = 0;
      n++;
      @(negedge clk);
    end
    check("conv_cycles", n, N);
    check("conv_busy", ok, 1);
    check("op_data", core_if.op_data, model_ops());
    data0 = core_if.op_data;
    ok = 1;
    for (int i = 0; i < ready_delay; i++) begin
      if (core_if.op_valid !== 1'b1 || core_if.op_data !== data0 || busy !== 1'b1) ok = 0;
      @(negedge clk);
    end
    check("req_stable", ok, 1);
    check("req_valid_at_accept", core_if.op_valid, 1);
    core_if.op_ready = 1'b1;
    @(negedge clk);
    core_if.op_ready = 1'b0;
    check("valid_drop", core_if.op_valid, 0);
    // a button press while waiting must be ignored and not queued
    btn_up = 1'b1;
    @(negedge clk);
    btn_up = 1'b0;
    @(negedge clk);
    check("wait_ignore_btn", {busy, disp_bcd}, {1'b1, model_disp()});
    core_if.res_data = 32'(res);
    core_if.res_done = 1'b1;
    @(negedge clk);
    core_if.res_done = 1'b0;
    core_if.res_data = $urandom();
    n = 0;
    while (show_res !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    m_show = 1;
    check("b2d_cycles", n, OPW);
    check("res_disp", disp_bcd, model_res(res));
    check("res_ovf", ovf, (res >= 10000) ? 1 : 0);
    check("show_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt [N];
    core_if.op_ready = 1'b0;
    core_if.res_done = 1'b0;
    core_if.res_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cursor", cursor, 0);
    check("rst_disp", disp_bcd, 0);
    check("rst_flags", {show_res, busy, ovf, core_if.op_valid}, 0);
    check("rst_op_data", core_if.op_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // up 3x then down 4x at cursor 0: 3, then wraps to 9
    repeat (3) press(0);
    check("up3", disp_bcd, model_disp());
    check("up3_d0", disp_bcd[3:0], 3);
    repeat (4) press(1);
    check("down4_d0", disp_bcd[3:0], 9);

    // cursor wrap both ways
    press(3);
    check("right_wrap", cursor, 3);
    press(2);
    check("left_wrap", cursor, 0);
    repeat (4) press(2);
    check("left4", cursor, m_cur);

    // random editing
    for (int i = 0; i < 24; i++) begin
      press(int'($urandom_range(0, 3)));
      check("rnd_edit", {cursor, disp_bcd}, {2'(m_cur), model_disp()});
    end

    // op1=48, op0=36, immediate accept, result 12
    tgt = '{6, 3, 8, 4};
    set_digits(tgt);
    check("ops_48_36", model_ops(), {32'd48, 32'd36});
    compute(0, 12);
    check("res_12", disp_bcd, 16'h0012);
    press(2);
    check("show_exit", {show_res, cursor, disp_bcd}, {1'b0, 2'(m_cur), model_disp()});

    // ready held low 20 cycles, overflowing result
    compute(20, 12345);
    check("res_ovf_9999", disp_bcd, 16'h9999);
    press(0);
    check("exit_no_act", disp_bcd, model_disp());

    // res_done outside WAIT is ignored
    core_if.res_data = 32'd77;
    core_if.res_done = 1'b1;
    @(negedge clk);
    core_if.res_done = 1'b0;
    @(negedge clk);
    check("stray_done", {show_res, busy, disp_bcd}, {2'b00, model_disp()});

    // random operands, delays and results; relaunch from SHOW on last round
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) tgt[i] = int'($urandom_range(0, 9));
      if (m_show) press(3);
      set_digits(tgt);
      compute(int'($urandom_range(0, 6)),
              (r % 2 == 1) ? longint'($urandom_range(10000, 2000000000))
                           : longint'($urandom_range(0, 9999)));
    end
    compute(2, 4321);
    press(1);

    // reset while a request is pending
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_valid", core_if.op_valid, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_flags", {show_res, busy, ovf, core_if.op_valid}, 0);
    check("midrst_state", {cursor, disp_bcd, core_if.op_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    press(0);
    check("post_rst_edit", disp_bcd, model_disp());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
